// File: rtl/usb_crc_pkg.sv
// usb_crc_pkg
// Shared definitions for the USB CRC16 generator/checker pair:
//   CRC16_POLY / CRC16_INIT / CRC16_RESIDUE  - polynomial, seed and good-packet residue
//   crc_chk_state_t                          - checker FSM state encoding
//   crc16_next(crc, din)                     - one serial LFSR step (wire-order bit in)
package usb_crc_pkg;

  localparam logic [15:0] CRC16_POLY    = 16'h8005;
  localparam logic [15:0] CRC16_INIT    = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUE = 16'h800D;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    CHECK = 2'd2
  } crc_chk_state_t;

  function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[15];
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/crc_16_lfsr.sv
// crc_16_lfsr
// Serial USB CRC16 shift register, shared by the generator and the checker.
// Ports:
//   clk, n_rst  clock / asynchronous active-low reset (reset value = INIT)
//   init        reload INIT; if en is also high the bit is folded into INIT
//   en          data is a valid bit this cycle
//   data        serial bit in wire order
//   crc[15:0]   current register contents
module crc_16_lfsr
  import usb_crc_pkg::*;
#(
  parameter logic [15:0] INIT = CRC16_INIT
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        init,
  input  logic        en,
  input  logic        data,
  output logic [15:0] crc
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      crc <= INIT;
    end else if (init) begin
      // a bit arriving with init is bit 0 of the new packet
      crc <= en ? crc16_next(INIT, data) : INIT;
    end else if (en) begin
      crc <= crc16_next(crc, data);
    end
  end

endmodule

// File: rtl/crc_16_chk.sv
// crc_16_chk
// Receive-side USB CRC16 checker. Consumes the de-stuffed packet body bit by
// bit (payload then received CRC16) and, one cycle after end-of-packet,
// reports whether residue, byte alignment and length were all good.
// Ports:
//   clk, n_rst       clock / asynchronous active-low reset
//   crc16_sop        start of packet (restarts from any state)
//   crc16_data       serial bit, LSB of each byte first
//   crc16_en         crc16_data valid
//   crc16_eop        end of packet (bit with en in this cycle is included)
//   crc16_busy       packet in progress
//   crc16_done       one-cycle result strobe
//   crc16_ok         last packet passed (held until next sop)
//   crc16_err        last packet failed (held until next sop)
//   crc16_err_cnt    [7:0] saturating failed-packet count, only with
//                    CRC16_CHK_ERRCNT_EN defined
//   crc16_byte_cnt   complete bytes received, saturates at MAX_BYTES+1
// Optional feature macro: CRC16_CHK_ERRCNT_EN
module crc_16_chk
  import usb_crc_pkg::*;
#(
  parameter int          MAX_BYTES   = 66,
  parameter int          BYTE_CNT_W  = 7,
  parameter logic [15:0] CRC_INIT    = CRC16_INIT,
  parameter logic [15:0] CRC_RESIDUE = CRC16_RESIDUE
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  crc16_sop,
  input  logic                  crc16_data,
  input  logic                  crc16_en,
  input  logic                  crc16_eop,
  output logic                  crc16_busy,
  output logic                  crc16_done,
  output logic                  crc16_ok,
  output logic                  crc16_err,
`ifdef CRC16_CHK_ERRCNT_EN
  output logic [7:0]            crc16_err_cnt,
`endif
  output logic [BYTE_CNT_W-1:0] crc16_byte_cnt
);

  localparam logic [BYTE_CNT_W-1:0] MAX_CNT = BYTE_CNT_W'(MAX_BYTES);
  localparam logic [BYTE_CNT_W-1:0] SAT_CNT = BYTE_CNT_W'(MAX_BYTES + 1);
  localparam logic [BYTE_CNT_W-1:0] MIN_CNT = BYTE_CNT_W'(2);

  crc_chk_state_t state, state_nxt;

  logic [15:0]           crc;
  logic [2:0]            bit_cnt;
  logic [BYTE_CNT_W-1:0] byte_cnt;
  logic                  ovf;
  logic                  ok_q;
  logic                  err_q;
  logic                  accept;
  logic                  pass;
  logic                  in_check;

  // bits are taken only inside a packet, or together with the sop that opens one
  assign accept   = crc16_en & (crc16_sop | (state == ACCUM));
  assign in_check = (state == CHECK);
  assign pass     = (crc == CRC_RESIDUE) && (bit_cnt == 3'd0) &&
                    (byte_cnt >= MIN_CNT) && !ovf;

  crc_16_lfsr #(
    .INIT (CRC_INIT)
  ) u_lfsr (
    .clk   (clk),
    .n_rst (n_rst),
    .init  (crc16_sop),
    .en    (accept),
    .data  (crc16_data),
    .crc   (crc)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    crc16_busy = 1'b0;
    crc16_done = 1'b0;
    case (state)
      IDLE: begin
        if (crc16_sop) state_nxt = ACCUM;
      end
      ACCUM: begin
        crc16_busy = 1'b1;
        if (crc16_sop)      state_nxt = ACCUM;
        else if (crc16_eop) state_nxt = CHECK;
      end
      CHECK: begin
        crc16_done = 1'b1;
        state_nxt  = crc16_sop ? ACCUM : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bit_cnt  <= 3'd0;
      byte_cnt <= '0;
      ovf      <= 1'b0;
    end else if (crc16_sop) begin
      bit_cnt  <= {2'b00, crc16_en};
      byte_cnt <= '0;
      ovf      <= 1'b0;
    end else if (accept) begin
      bit_cnt <= bit_cnt + 3'd1;
      if (bit_cnt == 3'd7) begin
        if (byte_cnt >= MAX_CNT) begin
          byte_cnt <= SAT_CNT;
          ovf      <= 1'b1;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ok_q  <= 1'b0;
      err_q <= 1'b0;
    end else if (crc16_sop) begin
      ok_q  <= 1'b0;
      err_q <= 1'b0;
    end else if (in_check) begin
      ok_q  <= pass;
      err_q <= !pass;
    end
  end

  // the verdict is visible in the done cycle itself, then held by ok_q/err_q
  assign crc16_ok       = ok_q  | (in_check &  pass);
  assign crc16_err      = err_q | (in_check & !pass);
  assign crc16_byte_cnt = byte_cnt;

`ifdef CRC16_CHK_ERRCNT_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      crc16_err_cnt <= 8'h00;
    end else if (in_check && !pass && (crc16_err_cnt != 8'hFF)) begin
      crc16_err_cnt <= crc16_err_cnt + 8'h01;
    end
  end
`else
  // error counter not present in this build
`endif

endmodule

// File: tb/tb_crc_16_chk.sv
// tb_crc_16_chk
// Self-checking bench for crc_16_chk: directed cases plus randomized packets,
// each judged by a packet-level reference model (residue over the bit list,
// length/alignment from the bit count).
// Define CRC16_CHK_ERRCNT_EN to also check crc16_err_cnt.
module tb_crc_16_chk;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       sop = 1'b0, data = 1'b0, en = 1'b0, eop = 1'b0;
  logic       busy, done, ok, err;
  logic [6:0] byte_cnt;
`ifdef CRC16_CHK_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int done_seen = 0;
  int model_errs = 0;
  logic pkt[$];

  always #5 clk = ~clk;

  crc_16_chk dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .crc16_sop      (sop),
    .crc16_data     (data),
    .crc16_en       (en),
    .crc16_eop      (eop),
    .crc16_busy     (busy),
    .crc16_done     (done),
    .crc16_ok       (ok),
    .crc16_err      (err),
`ifdef CRC16_CHK_ERRCNT_EN
    .crc16_err_cnt  (err_cnt),
`endif
    .crc16_byte_cnt (byte_cnt)
  );

  always @(negedge clk) if (done === 1'b1) done_seen++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // residue of the first n bits of pkt, starting from 0xFFFF
  function automatic logic [15:0] ref_crc(input int n);
    logic [15:0] r = 16'hFFFF;
    for (int i = 0; i < n; i++)
      r = {r[14:0], 1'b0} ^ (((pkt[i] ^ r[15]) == 1'b1) ? 16'h8005 : 16'h0000);
    return r;
  endfunction

  task automatic add_byte(input logic [7:0] b);
    for (int k = 0; k < 8; k++) pkt.push_back(b[k]);
  endtask

  // transmitted CRC: complement of the remainder, high bit first
  task automatic add_crc();
    logic [15:0] r;
    r = ref_crc(pkt.size());
    for (int k = 15; k >= 0; k--) pkt.push_back(~r[k]);
  endtask

  task automatic idle(input int n);
    sop = 0; en = 0; eop = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    n_rst = 0; sop = 0; en = 0; eop = 0;
    #3;
    model_errs = 0;
    @(posedge clk); #1;
    n_rst = 1;
    idle(1);
  endtask

  // start a packet with sop and send n random bits without ending it
  task automatic partial(input int n);
    for (int i = 0; i < n; i++) begin
      sop = (i == 0); en = 1; eop = 0; data = 1'($urandom);
      @(posedge clk); #1;
    end
    sop = 0; en = 0;
  endtask

  // drive pkt as one packet and check the verdict against the model
  task automatic send_pkt(input string tag, input bit gaps);
    int  nb, bytes, exp_cnt, d0;
    bit  exp_pass, late_eop;
    nb       = pkt.size();
    bytes    = nb / 8;
    exp_cnt  = (bytes > 67) ? 67 : bytes;
    exp_pass = (ref_crc(nb) == 16'h800D) && (nb % 8 == 0) && (bytes >= 2) && (bytes <= 66);
    late_eop = gaps && ($urandom_range(0, 1) == 1);
    for (int i = 0; i < nb; i++) begin
      if (i > 0 && gaps && $urandom_range(0, 3) == 0) begin
        sop = 0; en = 0; eop = 0; data = 1'($urandom);
        @(posedge clk); #1;
      end
      sop = (i == 0); en = 1; data = pkt[i]; eop = (i == nb - 1) && !late_eop;
      @(posedge clk); #1;
      if (i == 0) check_val({tag, ".busy"}, busy, 1);
    end
    if (late_eop) begin
      sop = 0; en = 0; eop = 1; data = 1'($urandom);
      @(posedge clk); #1;
    end
    sop = 0; en = 0; eop = 0;
    d0 = done_seen;
    check_val({tag, ".done"}, done, 1);
    check_val({tag, ".ok"}, ok, exp_pass);
    check_val({tag, ".err"}, err, !exp_pass);
    check_val({tag, ".byte_cnt"}, byte_cnt, exp_cnt);
    check_val({tag, ".busy_end"}, busy, 0);
    if (!exp_pass && model_errs < 255) model_errs++;
    @(posedge clk); #1;
    check_val({tag, ".done_pulse"}, done_seen - d0, 1);
    check_val({tag, ".done_low"}, done, 0);
    check_val({tag, ".ok_hold"}, ok, exp_pass);
    check_val({tag, ".err_hold"}, err, !exp_pass);
`ifdef CRC16_CHK_ERRCNT_EN
    check_val({tag, ".err_cnt"}, err_cnt, model_errs);
`endif
  endtask

  logic [7:0] tp_bytes [6] = '{8'h03, 8'h01, 8'h02, 8'h03, 8'h30, 8'h3A};

  initial begin
    int d0, len, kind;
    n_rst = 0;
    #2;
    check_val("rst.busy", busy, 0);
    check_val("rst.done", done, 0);
    check_val("rst.ok", ok, 0);
    check_val("rst.err", err, 0);
    check_val("rst.byte_cnt", byte_cnt, 0);
    do_reset();

    // empty payload: 16 zero bits
    pkt.delete();
    repeat (16) pkt.push_back(1'b0);
    send_pkt("empty", 0);

    // known payload with its CRC, then the same with payload bit 5 flipped
    pkt.delete();
    foreach (tp_bytes[i]) add_byte(tp_bytes[i]);
    add_crc();
    send_pkt("tp_good", 0);
    check_val("tp_good.cnt8", byte_cnt, 8);
    pkt[5] = ~pkt[5];
    send_pkt("tp_flip", 0);

    // misaligned: 16 zeros plus 3 bits
    pkt.delete();
    repeat (19) pkt.push_back(1'b0);
    send_pkt("misalign", 0);

    // 67 bytes: counter saturates, packet fails
    pkt.delete();
    for (int i = 0; i < 65; i++) add_byte(8'($urandom));
    add_crc();
    send_pkt("ovf67", 1);

    // sop mid-packet, then a valid empty packet: exactly one done
    d0 = done_seen;
    partial(20);
    idle(2);
    pkt.delete();
    repeat (16) pkt.push_back(1'b0);
    send_pkt("restart", 0);
    check_val("restart.single_done", done_seen - d0, 1);

    // reset in the middle of a packet
    d0 = done_seen;
    partial(20);
    n_rst = 0;
    #1;
    check_val("midrst.busy", busy, 0);
    check_val("midrst.ok", ok, 0);
    check_val("midrst.err", err, 0);
    check_val("midrst.byte_cnt", byte_cnt, 0);
    model_errs = 0;
    @(posedge clk); #1;
    n_rst = 1;
    idle(4);
    check_val("midrst.no_done", done_seen - d0, 0);

    // three failing packets then one passing
    for (int p = 0; p < 4; p++) begin
      pkt.delete();
      repeat (16) pkt.push_back(1'b0);
      if (p < 3) pkt[p] = 1'b1;
      send_pkt("errcnt", 0);
    end
`ifdef CRC16_CHK_ERRCNT_EN
    check_val("errcnt.three", err_cnt, 3);
`endif

    // randomized packets
    for (int t = 0; t < 40; t++) begin
      pkt.delete();
      kind = $urandom_range(0, 4);
      len  = (kind == 4) ? $urandom_range(63, 68) : $urandom_range(0, 20);
      if (kind == 3) begin
        repeat ($urandom_range(8, 200)) pkt.push_back(1'($urandom));
      end else begin
        for (int i = 0; i < len; i++) add_byte(8'($urandom));
        add_crc();
        if (kind == 1) pkt[$urandom_range(0, pkt.size() - 1)] ^= 1'b1;
        if (kind == 2) repeat ($urandom_range(1, 7)) pkt.push_back(1'($urandom));
      end
      send_pkt("rand", 1);
      idle($urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
